// File: rtl/wb_writeback_unit.sv
// Writeback unit: arbitrates ALU results and buffered load responses onto the register file write port.
// Optional macro WB_BYPASS_EN adds fwd_rs1_en/fwd_rs2_en so decode can take wb_data instead of stalling.
module wb_writeback_unit #(
    parameter int unsigned LD_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    output logic        ld_issue_ready,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [4:0]  mem_resp_rd,
    input  logic [2:0]  mem_resp_funct3,
    input  logic [1:0]  mem_resp_off,
    input  logic [31:0] mem_resp_data,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        stall,
    output logic        we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data
`ifdef WB_BYPASS_EN
    ,
    output logic        fwd_rs1_en,
    output logic        fwd_rs2_en
`endif
);

    localparam int unsigned PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(LD_DEPTH + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic [31:0] data;
    } ld_resp_t;

    ld_resp_t           resp_buf [LD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fill;
    logic [CNT_W-1:0]   outstanding;
    logic [31:0]        busy;
    logic [31:0]        busy_next;

    logic               full;
    logic               empty;
    logic               issue_ok;
    logic               push;
    logic               pop;
    logic               alu_claim;
    ld_resp_t           head;
    logic [31:0]        ld_data;
    logic               hit1;
    logic               hit2;

    // Byte/halfword selection and extension of the raw memory word.
    function automatic logic [31:0] extract_load(input ld_resp_t r);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (r.off)
            2'd0:    b = r.data[7:0];
            2'd1:    b = r.data[15:8];
            2'd2:    b = r.data[23:16];
            default: b = r.data[31:24];
        endcase
        h = r.off[1] ? r.data[31:16] : r.data[15:0];
        case (r.funct3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'd0, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'd0, h};
            default: res = r.data;
        endcase
        return res;
    endfunction

    always_comb begin
        full           = (fill == CNT_W'(LD_DEPTH));
        empty          = (fill == CNT_W'(0));
        ld_issue_ready = (outstanding < CNT_W'(LD_DEPTH));
        mem_resp_ready = !full;
        issue_ok       = ld_issue && ld_issue_ready;
        push           = mem_resp_valid && !full;
        alu_claim      = alu_valid && (alu_rd != 5'd0);
        pop            = !empty && !alu_claim;
        head           = resp_buf[rd_ptr];
        ld_data        = extract_load(head);
    end

    // Scoreboard update: a new issue to the same rd overrides the clear from a pop.
    always_comb begin
        busy_next = busy;
        if (pop && (head.rd != 5'd0)) begin
            busy_next[head.rd] = 1'b0;
        end
        if (issue_ok && (ld_issue_rd != 5'd0)) begin
            busy_next[ld_issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
`ifdef WB_BYPASS_EN
        hit1       = (rs1_addr != 5'd0) && busy[rs1_addr];
        hit2       = (rs2_addr != 5'd0) && busy[rs2_addr];
        fwd_rs1_en = we && (wb_addr == rs1_addr) && (rs1_addr != 5'd0);
        fwd_rs2_en = we && (wb_addr == rs2_addr) && (rs2_addr != 5'd0);
`else
        hit1 = (rs1_addr != 5'd0) && (busy[rs1_addr] || (we && (wb_addr == rs1_addr)));
        hit2 = (rs2_addr != 5'd0) && (busy[rs2_addr] || (we && (wb_addr == rs2_addr)));
`endif
        stall = hit1 || hit2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(LD_DEPTH); i++) begin
                resp_buf[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            outstanding <= '0;
            busy        <= '0;
            we          <= 1'b0;
            wb_addr     <= 5'd0;
            wb_data     <= 32'd0;
        end else begin
            if (push) begin
                resp_buf[wr_ptr] <= '{rd: mem_resp_rd, funct3: mem_resp_funct3,
                                      off: mem_resp_off, data: mem_resp_data};
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fill <= fill + CNT_W'(1);
            end else if (!push && pop) begin
                fill <= fill - CNT_W'(1);
            end

            // Responses may arrive with nothing outstanding (e.g. after reset); hold at zero.
            if (issue_ok && !pop) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (!issue_ok && pop && (outstanding != CNT_W'(0))) begin
                outstanding <= outstanding - CNT_W'(1);
            end

            busy <= busy_next;

            if (alu_claim) begin
                we      <= 1'b1;
                wb_addr <= alu_rd;
                wb_data <= alu_data;
            end else if (pop && (head.rd != 5'd0)) begin
                we      <= 1'b1;
                wb_addr <= head.rd;
                wb_data <= ld_data;
            end else begin
                we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Bench for wb_writeback_unit: queue-based reference model checked every cycle plus directed literal checks.
module tb_wb_writeback_unit;

    localparam int LD_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [4:0]  mem_resp_rd;
    logic [2:0]  mem_resp_funct3;
    logic [1:0]  mem_resp_off;
    logic [31:0] mem_resp_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        stall;
    logic        we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
`ifdef WB_BYPASS_EN
    logic        fwd_rs1_en;
    logic        fwd_rs2_en;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    wb_writeback_unit #(.LD_DEPTH(LD_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_rd(mem_resp_rd), .mem_resp_funct3(mem_resp_funct3),
        .mem_resp_off(mem_resp_off), .mem_resp_data(mem_resp_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .stall(stall),
        .we(we), .wb_addr(wb_addr), .wb_data(wb_data)
`ifdef WB_BYPASS_EN
        , .fwd_rs1_en(fwd_rs1_en), .fwd_rs2_en(fwd_rs2_en)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          rd;
        int          f3;
        int          off;
        logic [31:0] data;
    } resp_t;

    resp_t       mq[$];
    int          m_cnt = 0;
    bit          m_busy[32];
    logic        m_we = 1'b0;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_data = 32'd0;

    function automatic logic [31:0] model_extract(input int f3, input int off, input logic [31:0] d);
        logic [31:0] v;
        case (f3)
            0: begin v = (d >> (8 * off)) & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
            4: v = (d >> (8 * off)) & 32'hFF;
            1: begin v = (d >> (16 * (off / 2))) & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
            5: v = (d >> (16 * (off / 2))) & 32'hFFFF;
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic logic m_hit(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (m_busy[r]) return 1'b1;
`ifndef WB_BYPASS_EN
        if (m_we && m_addr == r) return 1'b1;
`endif
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model_step
        bit    claim;
        bit    pop;
        bit    push;
        bit    acc;
        resp_t h;
        if (reset) begin
            mq.delete();
            m_cnt = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
            m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        end else begin
            acc   = ld_issue && (m_cnt < LD_DEPTH);
            push  = mem_resp_valid && (mq.size() < LD_DEPTH);
            claim = alu_valid && (alu_rd != 5'd0);
            pop   = (mq.size() > 0) && !claim;
            m_we  = 1'b0;
            if (claim) begin
                m_we = 1'b1; m_addr = alu_rd; m_data = alu_data;
            end else if (pop) begin
                h = mq.pop_front();
                if (h.rd != 0) begin
                    m_busy[h.rd] = 0;
                    m_we   = 1'b1;
                    m_addr = 5'(h.rd);
                    m_data = model_extract(h.f3, h.off, h.data);
                end
            end
            if (acc && ld_issue_rd != 5'd0) m_busy[ld_issue_rd] = 1;
            m_cnt = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
            if (m_cnt < 0) m_cnt = 0;
            if (push) mq.push_back('{int'(mem_resp_rd), int'(mem_resp_funct3),
                                     int'(mem_resp_off), mem_resp_data});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("we", 32'(we), 32'(m_we));
            check("wb_addr", 32'(wb_addr), 32'(m_addr));
            check("wb_data", wb_data, m_data);
            check("stall", 32'(stall), 32'(m_hit(rs1_addr) | m_hit(rs2_addr)));
            check("ld_issue_ready", 32'(ld_issue_ready), 32'(m_cnt < LD_DEPTH));
            check("mem_resp_ready", 32'(mem_resp_ready), 32'(mq.size() < LD_DEPTH));
`ifdef WB_BYPASS_EN
            check("fwd_rs1_en", 32'(fwd_rs1_en), 32'(m_we && m_addr == rs1_addr && rs1_addr != 0));
            check("fwd_rs2_en", 32'(fwd_rs2_en), 32'(m_we && m_addr == rs2_addr && rs2_addr != 0));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        mem_resp_valid = 0; mem_resp_rd = 0; mem_resp_funct3 = 0;
        mem_resp_off = 0; mem_resp_data = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic respond(input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] off, input logic [31:0] d);
        mem_resp_valid = 1; mem_resp_rd = rd; mem_resp_funct3 = f3;
        mem_resp_off = off; mem_resp_data = d;
    endtask

    task automatic do_load(input string nm, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] off, input logic [31:0] d, input logic [31:0] exp);
        ld_issue = 1; ld_issue_rd = rd;
        tick();
        respond(rd, f3, off, d);
        tick();
        tick();
        #1;
        check({nm, "_we"}, 32'(we), 32'd1);
        check({nm, "_addr"}, 32'(wb_addr), 32'(rd));
        check({nm, "_data"}, wb_data, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1;
        @(posedge clk);
        chk_en = 1;
        tick();
        reset = 0;
        #1;
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(wb_addr), 32'd0);
        check("rst_data", wb_data, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ld_ready", 32'(ld_issue_ready), 32'd1);
        check("rst_resp_ready", 32'(mem_resp_ready), 32'd1);

        // ALU write and the registered-write hazard on rs1
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        tick();
        rs1_addr = 5;
        #1;
        check("alu_we", 32'(we), 32'd1);
        check("alu_addr", 32'(wb_addr), 32'd5);
        check("alu_data", wb_data, 32'hDEADBEEF);
`ifdef WB_BYPASS_EN
        check("alu_stall", 32'(stall), 32'd0);
        check("alu_fwd1", 32'(fwd_rs1_en), 32'd1);
`else
        check("alu_stall", 32'(stall), 32'd1);
`endif
        tick();

        // LB load with 3-cycle memory latency, busy stall on rs2
        ld_issue = 1; ld_issue_rd = 7;
        tick();
        rs2_addr = 7; #1; check("lb_busy1", 32'(stall), 32'd1);
        tick();
        rs2_addr = 7; #1; check("lb_busy2", 32'(stall), 32'd1);
        tick();
        rs2_addr = 7; respond(7, 3'b000, 2'd0, 32'h000080F0);
        #1; check("lb_busy3", 32'(stall), 32'd1);
        tick();
        rs2_addr = 7; #1; check("lb_busy_pop", 32'(stall), 32'd1);
        tick();
        rs2_addr = 7; #1;
        check("lb_we", 32'(we), 32'd1);
        check("lb_addr", 32'(wb_addr), 32'd7);
        check("lb_data", wb_data, 32'hFFFFFFF0);
`ifdef WB_BYPASS_EN
        check("lb_stall_wr", 32'(stall), 32'd0);
`else
        check("lb_stall_wr", 32'(stall), 32'd1);
`endif
        tick();
        rs2_addr = 7; #1; check("lb_stall_clr", 32'(stall), 32'd0);
        tick();

        // Extraction variants
        do_load("lbu",  5'd8,  3'b100, 2'd0, 32'h000080F0, 32'h000000F0);
        do_load("lh2",  5'd9,  3'b001, 2'd2, 32'h80F01234, 32'hFFFF80F0);
        do_load("lhu1", 5'd10, 3'b101, 2'd1, 32'h80F01234, 32'h00001234);
        do_load("lb3",  5'd11, 3'b000, 2'd3, 32'h80F01234, 32'hFFFFFF80);
        do_load("lbu2", 5'd12, 3'b100, 2'd2, 32'h80F01234, 32'h000000F0);
        do_load("lw",   5'd13, 3'b010, 2'd1, 32'h80F01234, 32'h80F01234);
        do_load("lf3",  5'd14, 3'b111, 2'd0, 32'h7E5A0001, 32'h7E5A0001);
        tick();

        // Outstanding limit
        ld_issue = 1; ld_issue_rd = 10;
        tick();
        ld_issue = 1; ld_issue_rd = 11;
        tick();
        #1; check("full_ready", 32'(ld_issue_ready), 32'd0);
        ld_issue = 1; ld_issue_rd = 12;
        tick();
        rs1_addr = 12; #1;
        check("ignored_busy", 32'(stall), 32'd0);
        check("still_full", 32'(ld_issue_ready), 32'd0);
        respond(10, 3'b010, 2'd0, 32'h0000000A);
        tick();
        #1; check("pop_cyc_ready", 32'(ld_issue_ready), 32'd0);
        tick();
        #1;
        check("after_pop_ready", 32'(ld_issue_ready), 32'd1);
        check("first_addr", 32'(wb_addr), 32'd10);
        respond(11, 3'b010, 2'd0, 32'h0000000B);
        tick();
        tick();
        #1; check("second_data", wb_data, 32'h0000000B);
        tick();

        // ALU contention delays the buffer head
        ld_issue = 1; ld_issue_rd = 13;
        tick();
        respond(13, 3'b010, 2'd0, 32'h13131313);
        alu_valid = 1; alu_rd = 3; alu_data = 32'h30;
        tick();
        #1; check("cont_a0", wb_data, 32'h30);
        alu_valid = 1; alu_rd = 3; alu_data = 32'h31;
        tick();
        #1; check("cont_a1", wb_data, 32'h31);
        alu_valid = 1; alu_rd = 3; alu_data = 32'h32;
        tick();
        #1; check("cont_a2", wb_data, 32'h32);
        tick();
        #1;
        check("cont_ld_addr", 32'(wb_addr), 32'd13);
        check("cont_ld_data", wb_data, 32'h13131313);
        tick();

        // rd=0 sources never write
        ld_issue = 1; ld_issue_rd = 0;
        tick();
        respond(0, 3'b010, 2'd0, 32'h99999999);
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        #1; check("x0_stall", 32'(stall), 32'd0);
        tick();
        #1; check("x0_we_a", 32'(we), 32'd0);
        tick();
        #1; check("x0_we_b", 32'(we), 32'd0);
        tick();

        // Reset with full buffer and busy bits
        ld_issue = 1; ld_issue_rd = 14; alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
        tick();
        ld_issue = 1; ld_issue_rd = 15; respond(14, 3'b010, 2'd0, 32'h14);
        alu_valid = 1; alu_rd = 1; alu_data = 32'h2;
        tick();
        respond(15, 3'b010, 2'd0, 32'h15);
        alu_valid = 1; alu_rd = 1; alu_data = 32'h3;
        tick();
        alu_valid = 1; alu_rd = 1; alu_data = 32'h4; rs1_addr = 14;
        #1;
        check("pre_rst_resp_ready", 32'(mem_resp_ready), 32'd0);
        check("pre_rst_stall", 32'(stall), 32'd1);
        reset = 1;
        tick();
        reset = 0; rs1_addr = 14;
        #1;
        check("post_rst_we", 32'(we), 32'd0);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_ld_ready", 32'(ld_issue_ready), 32'd1);
        check("post_rst_resp_ready", 32'(mem_resp_ready), 32'd1);
        respond(16, 3'b010, 2'd0, 32'h00001600);
        tick();
        tick();
        #1;
        check("late_we", 32'(we), 32'd1);
        check("late_addr", 32'(wb_addr), 32'd16);
        check("late_data", wb_data, 32'h00001600);
        check("late_ready", 32'(ld_issue_ready), 32'd1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
